// File: rtl/difftest_commit_unit.sv
// difftest_commit_unit: registered commit-tracking stage between the core's
// retire point and the Difftest reporting modules. Packs valid retiring slots
// downward, applies skip / x0-write rules, counts cycles and instructions,
// and stops reporting once the trap instruction has been committed.
module difftest_commit_unit #(
  parameter int          COMMIT_WIDTH = 2,
  parameter logic [63:0] PC_START     = 64'h8000_0000,
  parameter logic [6:0]  TRAP_OPCODE  = 7'h6b
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [COMMIT_WIDTH-1:0]    in_valid,
  input  logic [64*COMMIT_WIDTH-1:0] in_pc,
  input  logic [32*COMMIT_WIDTH-1:0] in_inst,
  input  logic [COMMIT_WIDTH-1:0]    in_wen,
  input  logic [5*COMMIT_WIDTH-1:0]  in_wdest,
  input  logic [64*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [COMMIT_WIDTH-1:0]    in_skip,
  input  logic [7:0]                 in_trap_code,
  output logic [COMMIT_WIDTH-1:0]    out_valid,
  output logic [64*COMMIT_WIDTH-1:0] out_pc,
  output logic [32*COMMIT_WIDTH-1:0] out_inst,
  output logic [COMMIT_WIDTH-1:0]    out_wen,
  output logic [8*COMMIT_WIDTH-1:0]  out_wdest,
  output logic [64*COMMIT_WIDTH-1:0] out_wdata,
  output logic [COMMIT_WIDTH-1:0]    out_skip,
  output logic                       trap_valid,
  output logic [7:0]                 trap_code,
  output logic [63:0]                trap_pc,
  output logic [63:0]                cycle_cnt,
  output logic [63:0]                instr_cnt,
  output logic                       halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e state_q;

  // Packed next-cycle view of the current retire group
  logic [COMMIT_WIDTH-1:0]    valid_d;
  logic [64*COMMIT_WIDTH-1:0] pc_d;
  logic [32*COMMIT_WIDTH-1:0] inst_d;
  logic [COMMIT_WIDTH-1:0]    wen_d;
  logic [8*COMMIT_WIDTH-1:0]  wdest_d;
  logic [64*COMMIT_WIDTH-1:0] wdata_d;
  logic [COMMIT_WIDTH-1:0]    skip_d;
  logic                       trap_hit;
  logic [63:0]                trap_pc_d;
  logic [63:0]                commit_n;
  int                         k;

  // Registered copies driving the outputs
  logic [COMMIT_WIDTH-1:0]    valid_q;
  logic [64*COMMIT_WIDTH-1:0] pc_q;
  logic [32*COMMIT_WIDTH-1:0] inst_q;
  logic [COMMIT_WIDTH-1:0]    wen_q;
  logic [8*COMMIT_WIDTH-1:0]  wdest_q;
  logic [64*COMMIT_WIDTH-1:0] wdata_q;
  logic [COMMIT_WIDTH-1:0]    skip_q;
  logic                       trap_valid_q;
  logic [7:0]                 trap_code_q;
  logic [63:0]                trap_pc_q;
  logic [63:0]                cycle_q;
  logic [63:0]                instr_q;
  logic                       halted_q;

  // Scan slots oldest-first, pack survivors downward, stop after the trap slot
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    valid_d   = '0;
    pc_d      = '0;
    inst_d    = '0;
    wen_d     = '0;
    wdest_d   = '0;
    wdata_d   = '0;
    skip_d    = '0;
    trap_hit  = 1'b0;
    trap_pc_d = '0;
    k         = 0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (in_valid[i] && !trap_hit) begin
        valid_d[k]          = 1'b1;
        pc_d[64*k +: 64]    = in_pc[64*i +: 64];
        inst_d[32*k +: 32]  = in_inst[32*i +: 32];
        // Writes to x0 are architecturally invisible, so they are not reported
        wen_d[k]            = in_wen[i] & (|in_wdest[5*i +: 5]);
        if (wen_d[k]) begin
          wdest_d[8*k +: 8]  = {3'b000, in_wdest[5*i +: 5]};
          wdata_d[64*k +: 64] = in_wdata[64*i +: 64];
        end
        // The reset PC commit is skipped by the reference model
        skip_d[k]           = in_skip[i] | (in_pc[64*i +: 64] == PC_START);
        if (in_inst[32*i +: 7] == TRAP_OPCODE) begin
          trap_hit  = 1'b1;
          trap_pc_d = in_pc[64*i +: 64];
        end
        k = k + 1;
      end
    end
    commit_n = 64'(k);
  end

  // RUN/HALTED state machine with all reported fields registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      valid_q      <= '0;
      pc_q         <= '0;
      inst_q       <= '0;
      wen_q        <= '0;
      wdest_q      <= '0;
      wdata_q      <= '0;
      skip_q       <= '0;
      trap_valid_q <= 1'b0;
      trap_code_q  <= '0;
      trap_pc_q    <= '0;
      cycle_q      <= '0;
      instr_q      <= '0;
      halted_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_RUN: begin
          valid_q      <= valid_d;
          pc_q         <= pc_d;
          inst_q       <= inst_d;
          wen_q        <= wen_d;
          wdest_q      <= wdest_d;
          wdata_q      <= wdata_d;
          skip_q       <= skip_d;
          cycle_q      <= cycle_q + 64'd1;
          instr_q      <= instr_q + commit_n;
          trap_valid_q <= trap_hit;
          if (trap_hit) begin
            trap_code_q <= in_trap_code;
            trap_pc_q   <= trap_pc_d;
            halted_q    <= 1'b1;
            state_q     <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          // Only reset leaves HALTED; nothing further is reported
          valid_q      <= '0;
          pc_q         <= '0;
          inst_q       <= '0;
          wen_q        <= '0;
          wdest_q      <= '0;
          wdata_q      <= '0;
          skip_q       <= '0;
          trap_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_inst   = inst_q;
  assign out_wen    = wen_q;
  assign out_wdest  = wdest_q;
  assign out_wdata  = wdata_q;
  assign out_skip   = skip_q;
  assign trap_valid = trap_valid_q;
  assign trap_code  = trap_code_q;
  assign trap_pc    = trap_pc_q;
  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;
  assign halted     = halted_q;

endmodule

// File: doc/difftest_commit_unit.md
# difftest_commit_unit

Parametrised commit-tracking stage that sits between the core's writeback/retire point and the Difftest DPI modules (InstrCommit, TrapEvent). It accepts up to COMMIT_WIDTH retiring instructions per cycle and packs them into the lowest output slots. It applies skip and x0-write rules, keeps cycle and retired-instruction counters, detects the trap instruction and halts commit reporting after it. It replaces ad-hoc per-top commit registers and supports multi-issue and pipelined cores.

## Interface

Parameters:
- COMMIT_WIDTH, 2, number of commit slots per cycle (1..4); slot 0 is oldest
- PC_START, 64'h8000_0000, reset PC; a commit at this PC is reported with skip set
- TRAP_OPCODE, 7'h6b, inst[6:0] value identifying the trap instruction

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  COMMIT_WIDTH  per-slot retire valid; any pattern is allowed, not necessarily contiguous
- in_pc  in  64*COMMIT_WIDTH  slot i PC at bits [64i+63:64i]
- in_inst  in  32*COMMIT_WIDTH  slot i instruction
- in_wen  in  COMMIT_WIDTH  slot i writes the GPR file
- in_wdest  in  5*COMMIT_WIDTH  slot i destination register
- in_wdata  in  64*COMMIT_WIDTH  slot i writeback data
- in_skip  in  COMMIT_WIDTH  core-requested skip for slot i (putch, MMIO)
- in_trap_code  in  8  a0[7:0], sampled on the trap edge
- out_valid  out  COMMIT_WIDTH  packed valid; always contiguous from slot 0
- out_pc / out_inst / out_wdata  out  64/32/64 per slot  packed copies of the inputs
- out_wen  out  COMMIT_WIDTH  packed write enable, with x0 suppression applied
- out_wdest  out  8*COMMIT_WIDTH  zero-extended destination register
- out_skip  out  COMMIT_WIDTH  packed skip
- trap_valid  out  1  one-cycle pulse, aligned with the trap slot on out_*
- trap_code  out  8  captured code, held until reset
- trap_pc  out  64  PC of the trap instruction, held until reset
- cycle_cnt  out  64  cycles spent in RUN
- instr_cnt  out  64  instructions reported
- halted  out  1  high after the trap has been reported

## Operation

- State machine: RUN and HALTED. Reset places the block in RUN. The state moves RUN→HALTED on the edge that captures a trap. HALTED is left only by reset.
- Slot selection on each edge while in RUN:
  - Scan valid slots from slot 0 upward.
  - The first valid slot whose inst[6:0]==TRAP_OPCODE is the trap slot. It is committed.
  - Valid slots with a higher index than the trap slot are discarded.
- Packing: the k-th surviving valid input slot, counting from 0, goes to output slot k. Order is preserved. Unused output slots have valid=0 and all fields 0.
- Per-slot rules:
  - out_skip = in_skip | (in_pc==PC_START).
  - out_wen = in_wen & (in_wdest!=0).
  - When out_wen is 0, out_wdest and out_wdata are 0.
- Counters, both wrapping modulo 2^64:
  - cycle_cnt increments by 1 on every edge in RUN, including the trap edge.
  - instr_cnt adds the number of committed slots on that edge. Skipped slots and the trap instruction are counted.
- HALTED:
  - in_valid is ignored and out_valid=0.
  - trap_valid=0.
  - Counters, trap_code and trap_pc are frozen.
  - halted=1.
- The reset value of every output is 0. State is RUN.

## Timing

- One-cycle latency: inputs sampled on edge N appear on out_*, cycle_cnt and instr_cnt after edge N. All outputs are registered; there is no combinational input→output path.
- trap_valid is high for exactly the cycle after the trap edge. halted rises on the same edge and stays high.
- No backpressure: every edge in RUN consumes its inputs.
- Reset asserted mid-operation clears all outputs, counters and state immediately, without a clock edge. The first edge after reset deassertion behaves as a normal RUN edge.
- A trap in slot 0 together with in_valid all zero in other slots is legal. A cycle with in_valid=0 still increments cycle_cnt.

## Test plan

- Reset, then slot 0 valid with pc=0x8000_0000, inst=0x0000_0013, wen=0 → next cycle: out_valid=01, out_skip[0]=1, cycle_cnt=1, instr_cnt=1.
- in_valid=10, slot 1 pc=0x8000_0010, wen=1, wdest=5, wdata=0x2A → next cycle: out_valid=01, out_pc[0]=0x8000_0010, out_wdest[0]=8'd5, out_wdata[0]=0x2A, out_skip=0.
- in_valid=11 for 3 consecutive cycles, slot 0 wen=1 wdest=0 wdata=0x55 → out_wen[0]=0, out_wdest[0]=0, out_wdata[0]=0; after 3 cycles cycle_cnt=3, instr_cnt=6.
- Slot 0 inst=0x0000_006b at pc=0x8000_0100, slot 1 valid, in_trap_code=0 → next cycle: out_valid=01, trap_valid=1 for one cycle, trap_pc=0x8000_0100, trap_code=0, halted=1. Ten further cycles with in_valid=11 → out_valid=00 and counters unchanged.
- After 5 RUN cycles, pulse reset between clock edges → all outputs read 0 before the next edge, halted=0. A subsequent commit gives cycle_cnt=1, instr_cnt=1.
